// File: rtl/bus_test_pkg.sv
// Shared types and helpers for the bus test sequencer.
//
// Contents:
//   seq_state_e   FSM state encoding; the values are visible on state_out.
//   step_w()      width of one step-memory word.
//   *_lsb()       bit offsets of each field within a step word.
//   Def*          the same offsets for the default configuration.
//
// Step word layout, MSB to LSB:
//   {en_mask[N], rd_mask[N], delay[DLY], addr[N-1..0][A], data[N-1..0][D]}
// Master 0 occupies the lowest addr/data slice.
package bus_test_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StDelay   = 3'd2,
    StDrive   = 3'd3,
    StWaitReq = 3'd4,
    StFinish  = 3'd5
  } seq_state_e;

  function automatic int unsigned step_w(input int unsigned n, input int unsigned a,
                                         input int unsigned d, input int unsigned dly);
    return 2 * n + dly + n * (a + d);
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned n, input int unsigned d);
    return n * d;
  endfunction

  function automatic int unsigned dly_lsb(input int unsigned n, input int unsigned a,
                                          input int unsigned d);
    return n * (a + d);
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned n, input int unsigned a,
                                         input int unsigned d, input int unsigned dly);
    return n * (a + d) + dly;
  endfunction

  function automatic int unsigned en_lsb(input int unsigned n, input int unsigned a,
                                         input int unsigned d, input int unsigned dly);
    return n * (a + d) + dly + n;
  endfunction

  // Field offsets for the default configuration (N=2, A=14, D=8, DLY=4).
  localparam int unsigned DefDataLsb = 0;
  localparam int unsigned DefAddrLsb = 2 * 8;
  localparam int unsigned DefDlyLsb  = 2 * (14 + 8);
  localparam int unsigned DefRdLsb   = DefDlyLsb + 4;
  localparam int unsigned DefEnLsb   = DefRdLsb + 2;
  localparam int unsigned DefStepW   = DefEnLsb + 2;

endpackage

// File: rtl/seq_step_mem.sv
// Step memory for the bus test sequencer.
//
// DEPTH x WIDTH array with synchronous write and a registered read port.
// Read data appears one cycle after raddr is presented. Contents are not
// reset, so programmed steps survive a sequencer reset.
//
// Ports:
//   clk    rising-edge clock
//   we     write strobe
//   waddr  write index
//   wdata  write word
//   raddr  read index (registered)
//   rdata  read word, valid the cycle after raddr
module seq_step_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_test_sequencer.sv
// Programmable stimulus sequencer for a multi-master bus test harness.
//
// Plays num_steps consecutive steps from the step memory, starting at
// start_idx (wrapping modulo STEP_DEPTH). Each step waits its pre-delay,
// drives the masked masters for HOLD_CYCLES cycles, then waits for every
// m_request to drop before loading the next step.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   cfg_we/addr/wdata     step-memory write port, honoured only while idle
//   start/start_idx/num_steps  launch a run (sampled only in IDLE)
//   abort                 drop to IDLE from any busy state, no done
//   m_request             per-master transaction-in-progress flags
//   m_enable/read_en/addr/data  registered master stimulus
//   busy, done, state_out run status; done is a one-cycle pulse
//   timeout_err           sticky WAIT_REQ timeout flag (timeout build only)
//
// Optional feature: define BUS_TEST_SEQ_TIMEOUT_EN to add TIMEOUT_CYCLES and
// timeout_err; WAIT_REQ then gives up after TIMEOUT_CYCLES cycles.
module bus_test_sequencer
  import bus_test_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned STEP_DEPTH  = 16,
  parameter int unsigned DLY_WIDTH   = 4,
  parameter int unsigned HOLD_CYCLES = 3
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_we,
  input  logic [$clog2(STEP_DEPTH)-1:0]        cfg_addr,
  input  logic [step_w(NUM_MASTERS, ADDR_WIDTH, DATA_WIDTH, DLY_WIDTH)-1:0] cfg_wdata,
  input  logic                                 start,
  input  logic [$clog2(STEP_DEPTH)-1:0]        start_idx,
  input  logic [$clog2(STEP_DEPTH):0]          num_steps,
  input  logic                                 abort,
  input  logic [NUM_MASTERS-1:0]               m_request,
  output logic [NUM_MASTERS-1:0]               m_enable,
  output logic [NUM_MASTERS-1:0]               m_read_en,
  output logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           state_out
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
  ,
  output logic                                 timeout_err
`endif
);

  localparam int unsigned N       = NUM_MASTERS;
  localparam int unsigned StepW   = step_w(N, ADDR_WIDTH, DATA_WIDTH, DLY_WIDTH);
  localparam int unsigned IdxW    = $clog2(STEP_DEPTH);
  localparam int unsigned RemW    = IdxW + 1;
  localparam int unsigned CntW    = (DLY_WIDTH > 4) ? DLY_WIDTH : 4;
  localparam int unsigned AddrLsb = addr_lsb(N, DATA_WIDTH);
  localparam int unsigned DlyLsb  = dly_lsb(N, ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned RdLsb   = rd_lsb(N, ADDR_WIDTH, DATA_WIDTH, DLY_WIDTH);
  localparam int unsigned EnLsb   = en_lsb(N, ADDR_WIDTH, DATA_WIDTH, DLY_WIDTH);

  seq_state_e                  state_q, state_d;
  logic [IdxW-1:0]             ptr_q, ptr_d;
  logic [RemW-1:0]             remain_q, remain_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [StepW-1:0]            step_q, step_d;
  logic [N-1:0]                m_enable_q, m_enable_d;
  logic [N-1:0]                m_read_en_q, m_read_en_d;
  logic [N*ADDR_WIDTH-1:0]     m_addr_q, m_addr_d;
  logic [N*DATA_WIDTH-1:0]     m_data_q, m_data_d;
  logic                        done_q, done_d;
  logic [StepW-1:0]            mem_rdata;
  logic [DLY_WIDTH-1:0]        ld_dly;

`ifdef BUS_TEST_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_err_q, timeout_err_d;
`endif

  // Read address follows ptr_d so the word is already registered when LOAD
  // is entered; LOAD then only has to decide between DELAY and DRIVE.
  seq_step_mem #(
    .DEPTH (STEP_DEPTH),
    .WIDTH (StepW)
  ) u_step_mem (
    .clk   (clk),
    .we    (cfg_we && (state_q == StIdle)),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (ptr_d),
    .rdata (mem_rdata)
  );

  assign ld_dly = mem_rdata[DlyLsb +: DLY_WIDTH];

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d    = start_idx;
          // A run can never cover more than the whole memory.
          remain_d = (num_steps > RemW'(STEP_DEPTH)) ? RemW'(STEP_DEPTH) : num_steps;
          state_d  = (num_steps == '0) ? StFinish : StLoad;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      StLoad: begin
        step_d = mem_rdata;
        if (ld_dly != '0) begin
          state_d = StDelay;
          cnt_d   = CntW'(ld_dly) - CntW'(1);
        end else begin
          state_d = StDrive;
          cnt_d   = CntW'(HOLD_CYCLES - 1);
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          state_d = StDrive;
          cnt_d   = CntW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StWaitReq;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitReq: begin
        if (m_request == '0) begin
          ptr_d    = ptr_q + IdxW'(1);
          remain_d = remain_q - RemW'(1);
          state_d  = (remain_q == RemW'(1)) ? StFinish : StLoad;
        end
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
        else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Outputs are registered from the next state, so they line up with
  // state_out and vanish in the same cycle as an abort.
  always_comb begin
    m_enable_d  = '0;
    m_read_en_d = '0;
    m_addr_d    = '0;
    m_data_d    = '0;
    done_d      = (state_d == StFinish);
    if (state_d == StDrive) begin
      m_enable_d  = step_d[EnLsb +: N];
      m_read_en_d = step_d[RdLsb +: N] & step_d[EnLsb +: N];
      for (int i = 0; i < int'(N); i++) begin
        if (step_d[EnLsb + i]) begin
          m_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = step_d[AddrLsb + i*ADDR_WIDTH +: ADDR_WIDTH];
          m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = step_d[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end else if (state_d == StWaitReq) begin
      m_read_en_d = m_read_en_q;
      m_addr_d    = m_addr_q;
      m_data_d    = m_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remain_q    <= '0;
      cnt_q       <= '0;
      step_q      <= '0;
      m_enable_q  <= '0;
      m_read_en_q <= '0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
      done_q      <= 1'b0;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      m_enable_q  <= m_enable_d;
      m_read_en_q <= m_read_en_d;
      m_addr_q    <= m_addr_d;
      m_data_q    <= m_data_d;
      done_q      <= done_d;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign m_enable  = m_enable_q;
  assign m_read_en = m_read_en_q;
  assign m_addr    = m_addr_q;
  assign m_data    = m_data_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign state_out = state_q;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_bus_test_sequencer.sv
// Directed bench for bus_test_sequencer in its default configuration
// (2 masters, 14-bit address, 8-bit data, 16 steps, 4-bit delay, hold 3).
module tb_bus_test_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [51:0] cfg_wdata;
  logic        start;
  logic [3:0]  start_idx;
  logic [4:0]  num_steps;
  logic        abort;
  logic [1:0]  m_request;
  logic [1:0]  m_enable;
  logic [1:0]  m_read_en;
  logic [27:0] m_addr;
  logic [15:0] m_data;
  logic        busy;
  logic        done;
  logic [2:0]  state_out;
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_test_sequencer #(
    .NUM_MASTERS (2),
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (14),
    .STEP_DEPTH  (16),
    .DLY_WIDTH   (4),
    .HOLD_CYCLES (3)
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (5)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .start_idx (start_idx),
    .num_steps (num_steps),
    .abort     (abort),
    .m_request (m_request),
    .m_enable  (m_enable),
    .m_read_en (m_read_en),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
`ifdef BUS_TEST_SEQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  rd;
    logic [3:0]  dly;
    logic [13:0] a0;
    logic [13:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          x_lat;
    logic [1:0]  x_en;
    logic [1:0]  x_rd;
    logic [13:0] x_a0;
    logic [13:0] x_a1;
    logic [7:0]  x_d0;
    logic [7:0]  x_d1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the next negedge.
  task automatic write_step(input int idx, input logic [1:0] en, input logic [1:0] rd,
                            input logic [3:0] dly, input logic [13:0] a0,
                            input logic [13:0] a1, input logic [7:0] d0,
                            input logic [7:0] d1);
    cfg_addr  = 4'(idx);
    cfg_wdata = {en, rd, dly, a1, a0, d1, d0};
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Pulses start and counts cycles until the first nonzero m_enable.
  task automatic launch(input int idx, input int num, output int lat);
    start_idx = 4'(idx);
    num_steps = 5'(num);
    start     = 1'b1;
    lat       = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (m_enable != 2'b00) break;
    end
  endtask

  task automatic idle_wait();
    for (int k = 0; k < 60; k++) begin
      if (state_out == 3'd0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int hold;
    int cnt;

    vecs[0] = '{2'b01, 2'b00, 4'd0, 14'd1001, 14'd77, 8'd212, 8'd55,
                2, 2'b01, 2'b00, 14'd1001, 14'd0, 8'd212, 8'd0};
    vecs[1] = '{2'b11, 2'b11, 4'd0, 14'd5098, 14'd5097, 8'd17, 8'd34,
                2, 2'b11, 2'b11, 14'd5098, 14'd5097, 8'd17, 8'd34};
    vecs[2] = '{2'b10, 2'b11, 4'd0, 14'd4000, 14'd16383, 8'd1, 8'd255,
                2, 2'b10, 2'b10, 14'd0, 14'd16383, 8'd0, 8'd255};
    vecs[3] = '{2'b01, 2'b01, 4'd3, 14'd2, 14'd3, 8'd4, 8'd5,
                5, 2'b01, 2'b01, 14'd2, 14'd0, 8'd4, 8'd0};
    vecs[4] = '{2'b11, 2'b01, 4'd1, 14'd100, 14'd200, 8'd10, 8'd20,
                3, 2'b11, 2'b01, 14'd100, 14'd200, 8'd10, 8'd20};

    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    start_idx = '0; num_steps = '0; abort = 1'b0; m_request = 2'b00;

    // Reset state
    #2;
    check("reset state", 64'(state_out), 64'd0);
    check("reset outputs", 64'({m_enable, m_read_en, m_addr, m_data, busy, done}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single-step runs with m_request idle.
    for (int v = 0; v < 5; v++) begin
      write_step(0, vecs[v].en, vecs[v].rd, vecs[v].dly, vecs[v].a0, vecs[v].a1,
                 vecs[v].d0, vecs[v].d1);
      launch(0, 1, lat);
      check($sformatf("v%0d latency", v), 64'(lat), 64'(vecs[v].x_lat));
      check($sformatf("v%0d en", v), 64'(m_enable), 64'(vecs[v].x_en));
      check($sformatf("v%0d rd", v), 64'(m_read_en), 64'(vecs[v].x_rd));
      check($sformatf("v%0d addr0", v), 64'(m_addr[13:0]), 64'(vecs[v].x_a0));
      check($sformatf("v%0d addr1", v), 64'(m_addr[27:14]), 64'(vecs[v].x_a1));
      check($sformatf("v%0d data0", v), 64'(m_data[7:0]), 64'(vecs[v].x_d0));
      check($sformatf("v%0d data1", v), 64'(m_data[15:8]), 64'(vecs[v].x_d1));
      hold = 0;
      for (int k = 0; k < 16; k++) begin
        if (m_enable != vecs[v].x_en) break;
        hold++;
        @(negedge clk);
      end
      check($sformatf("v%0d hold", v), 64'(hold), 64'd3);
      check($sformatf("v%0d wait state", v), 64'(state_out), 64'd4);
      check($sformatf("v%0d wait en/addr", v), 64'({m_enable, m_addr[13:0]}),
            64'({2'b00, vecs[v].x_a0}));
      @(negedge clk);
      check($sformatf("v%0d finish", v), 64'({state_out, done}), 64'({3'd5, 1'b1}));
      @(negedge clk);
      check($sformatf("v%0d idle", v), 64'({state_out, done, busy}), 64'({3'd0, 1'b0, 1'b0}));
    end

    // num_steps == 0 goes straight to FINISH.
    start_idx = 4'd0; num_steps = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero steps finish", 64'({state_out, done, m_enable}), 64'({3'd5, 1'b1, 2'b00}));
    @(negedge clk);
    check("zero steps idle", 64'({state_out, done}), 64'({3'd0, 1'b0}));

    // Delay plus wrap from step 15 to step 0.
    write_step(15, 2'b01, 2'b00, 4'd8, 14'd300, 14'd0, 8'd30, 8'd0);
    write_step(0, 2'b10, 2'b10, 4'd0, 14'd0, 14'd400, 8'd0, 8'd40);
    launch(15, 2, lat);
    check("wrap latency", 64'(lat), 64'd10);
    check("wrap step15 addr0", 64'({m_enable, m_addr[13:0]}), 64'({2'b01, 14'd300}));
    cnt = 0;
    hold = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hold++;
      if (done) cnt++;
      if (m_enable == 2'b10) break;
    end
    check("wrap step gap", 64'(hold), 64'd5);
    check("wrap no early done", 64'(cnt), 64'd0);
    check("wrap step0 slices", 64'({m_read_en, m_addr, m_data}),
          64'({2'b10, 14'd400, 14'd0, 8'd40, 8'd0}));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin cnt = k + 1; break; end
    end
    check("wrap done timing", 64'(cnt), 64'd4);
    idle_wait();

    // Request hold-off; start and cfg_we while busy must be ignored.
    write_step(0, 2'b11, 2'b00, 4'd0, 14'd50, 14'd60, 8'd5, 8'd6);
    launch(0, 1, lat);
    m_request = 2'b11;
    for (int k = 0; k < 10; k++) begin
      if (state_out == 3'd4) break;
      @(negedge clk);
    end
    check("holdoff enters wait", 64'(state_out), 64'd4);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (state_out == 3'd4 && m_enable == 2'b00) cnt++;
      if (k == 5) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = {52{1'b1}};
        start = 1'b1; num_steps = 5'd0;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    check("holdoff stays in wait", 64'(cnt), 64'd20);
    m_request = 2'b00;
    @(negedge clk);
    check("holdoff release", 64'({state_out, done}), 64'({3'd5, 1'b1}));
    @(negedge clk);
    launch(0, 1, lat);
    check("busy cfg_we dropped", 64'({m_addr, m_data}),
          64'({14'd60, 14'd50, 8'd6, 8'd5}));
    idle_wait();

    // Abort during DRIVE.
    write_step(0, 2'b01, 2'b01, 4'd0, 14'd321, 14'd0, 8'd7, 8'd0);
    launch(0, 1, lat);
    check("abort in drive", 64'(state_out), 64'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort outputs", 64'({state_out, busy, done, m_enable, m_read_en, m_addr, m_data}),
          64'd0);
    cnt = 0;
    repeat (6) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check("abort no done", 64'(cnt), 64'd0);

    // Reset mid-DELAY, then replay the preserved step.
    write_step(0, 2'b01, 2'b00, 4'd8, 14'd1234, 14'd0, 8'd99, 8'd0);
    start_idx = 4'd0; num_steps = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("in delay", 64'(state_out), 64'd2);
    reset = 1'b0;
    #1;
    check("async reset", 64'({state_out, busy, m_enable}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch(0, 1, lat);
    check("replay latency", 64'(lat), 64'd10);
    check("replay step", 64'({m_enable, m_addr[13:0], m_data[7:0]}),
          64'({2'b01, 14'd1234, 8'd99}));
    idle_wait();

`ifdef BUS_TEST_SEQ_TIMEOUT_EN
    // Stuck request trips the timeout.
    write_step(0, 2'b01, 2'b00, 4'd0, 14'd9, 14'd0, 8'd9, 8'd0);
    launch(0, 1, lat);
    m_request = 2'b01;
    for (int k = 0; k < 10; k++) begin
      if (state_out == 3'd4) break;
      @(negedge clk);
    end
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (state_out != 3'd4) break;
      cnt++;
      @(negedge clk);
    end
    check("timeout wait cycles", 64'(cnt), 64'd5);
    check("timeout idle", 64'({state_out, done, timeout_err}), 64'({3'd0, 1'b0, 1'b1}));
    m_request = 2'b00;
    @(negedge clk);
    check("timeout sticky", 64'(timeout_err), 64'd1);
    launch(0, 1, lat);
    check("timeout cleared", 64'(timeout_err), 64'd0);
    idle_wait();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_test_sequencer.md
Name: bus_test_sequencer

Overview:
- Parametrised, programmable stimulus sequencer for the two-or-more-master bus test harness.
- Replaces hard-coded scenario states with a step memory. Each step sets per-master enable, read/write, address and data, plus a pre-delay.
- On `start`, plays a run of consecutive steps. After each step it waits for all master requests to drop before moving on.
- Drives the masters' enable/read_en/addr/data inputs directly.

Parameters:
- NUM_MASTERS, 2, number of bus masters driven.
- DATA_WIDTH, 8, per-master write-data width.
- ADDR_WIDTH, 14, per-master address width.
- STEP_DEPTH, 16, number of step-memory entries (power of 2).
- DLY_WIDTH, 4, width of the per-step pre-delay field.
- HOLD_CYCLES, 3, cycles enables stay asserted in DRIVE (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  step-memory write strobe; accepted only when busy=0.
- cfg_addr  in  log2(STEP_DEPTH)  step-memory write index.
- cfg_wdata  in  STEP_W  step word {en_mask, rd_mask, delay, addr[N-1:0], data[N-1:0]}.
- start  in  1  begin a run; sampled only in IDLE.
- start_idx  in  log2(STEP_DEPTH)  first step of the run.
- num_steps  in  log2(STEP_DEPTH)+1  steps to play, 0..STEP_DEPTH.
- abort  in  1  terminate the run immediately.
- m_request  in  NUM_MASTERS  per-master "transaction in progress" flags.
- m_enable  out  NUM_MASTERS  per-master enable.
- m_read_en  out  NUM_MASTERS  per-master read(1)/write(0).
- m_addr  out  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i at slice i.
- m_data  out  NUM_MASTERS*DATA_WIDTH  flattened write data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- state_out  out  3  current FSM state encoding.

Behaviour:
- Reset: FSM=IDLE. All outputs 0, including `done`. Step pointer and counters cleared. Step-memory contents are not reset.
- States: IDLE=0, LOAD=1, DELAY=2, DRIVE=3, WAIT_REQ=4, FINISH=5.
- IDLE:
  - `cfg_we` writes the step memory.
  - `start` latches ptr=start_idx and remain=num_steps.
  - Next state is LOAD, or FINISH if num_steps==0.
  - Outputs held at 0.
- LOAD: reads the step at ptr into a holding register (one cycle). Goes to DELAY if delay!=0, else to DRIVE.
- DELAY: counts the step's delay value in cycles, outputs 0, then goes to DRIVE.
- DRIVE:
  - m_enable=en_mask, m_read_en=rd_mask & en_mask.
  - m_addr/m_data come from the step; unmasked masters get 0.
  - Held exactly HOLD_CYCLES cycles, then WAIT_REQ.
- WAIT_REQ:
  - m_enable=0; addr/data/read_en are held.
  - Leaves on the first cycle m_request==0.
  - Then ptr=ptr+1 (wraps modulo STEP_DEPTH) and remain-=1.
  - Goes to LOAD if remain!=0, else FINISH.
- FINISH: all outputs 0, done=1 for one cycle, then IDLE.
- Latency: start to first m_enable = 2 + delay cycles.
- Boundary conditions:
  - `start` while busy: ignored.
  - `cfg_we` while busy: dropped.
  - `abort` in any non-IDLE state: next cycle IDLE, outputs 0, no `done`. Abort has priority over every other transition.
  - Run longer than STEP_DEPTH is impossible. A run starting at a nonzero index wraps to step 0.
  - m_request already 0 on WAIT_REQ entry: exits after one cycle.
  - Reset asserted mid-run: immediate return to the reset state; step memory is preserved.

Optional Feature:
- Macro BUS_TEST_SEQ_TIMEOUT_EN.
- With it defined:
  - Parameter TIMEOUT_CYCLES (default 255) and output `timeout_err` (1 bit, sticky) are added.
  - If WAIT_REQ lasts TIMEOUT_CYCLES cycles, the FSM sets timeout_err and aborts to IDLE with no `done`.
  - timeout_err clears on the next accepted `start` or on reset.
- Without it: WAIT_REQ waits indefinitely, and the port and parameter are absent.

Decomposition:
- Package bus_test_pkg holds:
  - the FSM state enum;
  - function step_w(N, A, D, DLY) = 2N + DLY + N(A+D);
  - field-offset localparams for en_mask, rd_mask, delay, addr and data within the step word.
- Sub-module seq_step_mem: STEP_DEPTH x STEP_W synchronous-write, registered-read memory. Its one-cycle read latency is what LOAD covers.

Test Plan:
- Single write:
  - Step0 = {en=01, rd=00, dly=0, addr0=1001, data0=212}; start_idx=0, num_steps=1.
  - m_enable=01 for 3 cycles, starting 2 cycles after start. addr0=1001, data0=212.
  - done pulses once m_request returns to 0.
- Simultaneous two-master read:
  - Step = {en=11, rd=11, addr0=5098, addr1=5097}.
  - Both enables and read_en high for 3 cycles, with the correct address slices.
- Delay and multi-step wrap:
  - STEP_DEPTH=16, start_idx=15, num_steps=2, step15 dly=8.
  - First enable appears 10 cycles after start. Step 0 plays second. done after step 0.
- Request hold-off: m_request held 11 for 20 cycles after DRIVE -> FSM stays in WAIT_REQ (state_out=4) until release, then proceeds.
- Abort and reset:
  - abort during DRIVE -> outputs 0 and IDLE next cycle, no done.
  - reset low mid-DELAY -> outputs 0 asynchronously. A following run replays the preserved step memory correctly.
- Timeout (macro on, TIMEOUT_CYCLES=5): m_request stuck 1 -> timeout_err=1 after 5 WAIT_REQ cycles, FSM returns to IDLE, and the next start clears timeout_err.
